// File: rtl/vga_timing_gen.sv
// Pixel timing generator: cascaded horizontal/vertical counters with fully registered
// coordinates, active-video flag, sync levels and line/frame start strobes.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       active,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HLast      = 10'(HTotal - 1);
  localparam logic [9:0] VLast      = 10'(VTotal - 1);
  localparam logic [9:0] HActive    = 10'(H_ACTIVE);
  localparam logic [9:0] VActive    = 10'(V_ACTIVE);
  localparam logic [9:0] HSyncStart = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HSyncEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VSyncStart = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VSyncEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       active_q, active_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;

  // Decode from the next counter values so every output register describes
  // the same slot as pos_x/pos_y; with ce low the decode reproduces the held slot.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (ce) begin
      if (x_q == HLast) begin
        x_d = 10'd0;
        y_d = (y_q == VLast) ? 10'd0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end

    active_d      = (x_d < HActive) && (y_d < VActive);
    hsync_d       = ((x_d >= HSyncStart) && (x_d < HSyncEnd)) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = ((y_d >= VSyncStart) && (y_d < VSyncEnd)) ? SYNC_POL : ~SYNC_POL;
    line_start_d  = (x_d == 10'd0);
    frame_start_d = (x_d == 10'd0) && (y_d == 10'd0);
  end

  // Reset parks on the last slot of a frame so the first enabled edge lands on (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q           <= HLast;
      y_q           <= VLast;
      active_q      <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pos_x       = x_q;
  assign pos_y       = y_q;
  assign active      = active_q;
  assign o_hsync     = hsync_q;
  assign o_vsync     = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 instances of both sync polarities
// plus a miniature-timing instance used for whole-frame checks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset;
  logic ce;

  logic [9:0] px, py, p1_x, p1_y, s_x, s_y;
  logic act, hs, vs, ls, fs;
  logic p1_act, p1_hs, p1_vs, p1_ls, p1_fs;
  logic s_act, s_hs, s_vs, s_ls, s_fs;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut (
    .clk(clk), .reset(reset), .ce(ce), .pos_x(px), .pos_y(py), .active(act),
    .o_hsync(hs), .o_vsync(vs), .line_start(ls), .frame_start(fs)
  );

  vga_timing_gen #(.SYNC_POL(1'b1)) dut_pos (
    .clk(clk), .reset(reset), .ce(ce), .pos_x(p1_x), .pos_y(p1_y), .active(p1_act),
    .o_hsync(p1_hs), .o_vsync(p1_vs), .line_start(p1_ls), .frame_start(p1_fs)
  );

  // Miniature timing: 15 slots per line (hsync 10..12), 8 lines per frame (vsync 5..6).
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_small (
    .clk(clk), .reset(reset), .ce(ce), .pos_x(s_x), .pos_y(s_y), .active(s_act),
    .o_hsync(s_hs), .o_vsync(s_vs), .line_start(s_ls), .frame_start(s_fs)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int bx, by, sx, sy;
    int berr, serr, froz, adv;
    int s_fs_cnt, s_fs_at, s_vs_cnt, s_act_cnt, s_hs_cnt;
    logic [9:0] prev_x, prev_y;
    logic prev_act, prev_hs, prev_ls;
    logic e_act, e_hs, e_vs, e_ls, e_fs;

    // Reset must win over ce low.
    reset = 1'b1;
    ce    = 1'b0;
    tick();
    check("rst_x", 32'(px), 32'd799);
    check("rst_y", 32'(py), 32'd524);
    ce = 1'b1;
    tick();
    check("rst_x_ce", 32'(px), 32'd799);
    check("rst_active", 32'(act), 32'd0);
    check("rst_hsync", 32'(hs), 32'd1);
    check("rst_vsync", 32'(vs), 32'd1);
    check("rst_line_start", 32'(ls), 32'd0);
    check("rst_frame_start", 32'(fs), 32'd0);
    check("rst_hsync_pos", 32'(p1_hs), 32'd0);
    check("rst_vsync_pos", 32'(p1_vs), 32'd0);
    check("rst_small_x", 32'(s_x), 32'd14);
    check("rst_small_y", 32'(s_y), 32'd7);

    // First edge after release presents (0,0).
    reset = 1'b0;
    tick();
    check("first_x", 32'(px), 32'd0);
    check("first_y", 32'(py), 32'd0);
    check("first_active", 32'(act), 32'd1);
    check("first_line_start", 32'(ls), 32'd1);
    check("first_frame_start", 32'(fs), 32'd1);
    check("first_hsync", 32'(hs), 32'd1);
    check("small_first_fs", 32'(s_fs), 32'd1);

    bx = 0; by = 0; sx = 0; sy = 0;
    berr = 0; serr = 0;
    s_fs_cnt = 0; s_fs_at = 0; s_vs_cnt = 0; s_act_cnt = 0; s_hs_cnt = 0;
    for (int k = 1; k <= 800; k++) begin
      tick();
      if (bx == 799) begin
        bx = 0;
        by = (by == 524) ? 0 : by + 1;
      end else begin
        bx = bx + 1;
      end
      if (sx == 14) begin
        sx = 0;
        sy = (sy == 7) ? 0 : sy + 1;
      end else begin
        sx = sx + 1;
      end

      e_act = (bx < 640) && (by < 480);
      e_hs  = !((bx >= 656) && (bx < 752));
      e_vs  = !((by >= 490) && (by < 492));
      e_ls  = (bx == 0);
      e_fs  = (bx == 0) && (by == 0);
      if (px !== 10'(bx) || py !== 10'(by) || act !== e_act || hs !== e_hs || vs !== e_vs ||
          ls !== e_ls || fs !== e_fs || p1_hs !== !e_hs || p1_vs !== !e_vs) berr++;

      e_act = (sx < 8) && (sy < 4);
      e_hs  = !((sx >= 10) && (sx < 13));
      e_vs  = !((sy >= 5) && (sy < 7));
      e_ls  = (sx == 0);
      e_fs  = (sx == 0) && (sy == 0);
      if (s_x !== 10'(sx) || s_y !== 10'(sy) || s_act !== e_act || s_hs !== e_hs ||
          s_vs !== e_vs || s_ls !== e_ls || s_fs !== e_fs) serr++;

      if (k <= 120) begin
        if (s_fs === 1'b1) begin
          s_fs_cnt++;
          s_fs_at = k;
        end
        if (s_vs === 1'b0) s_vs_cnt++;
        if (s_act === 1'b1) s_act_cnt++;
        if (s_hs === 1'b0) s_hs_cnt++;
      end

      if (k == 74)  check("small_vsync_before", 32'(s_vs), 32'd1);
      if (k == 75)  check("small_vsync_start", 32'(s_vs), 32'd0);
      if (k == 639) check("active_last", 32'(act), 32'd1);
      if (k == 640) check("active_fall", 32'(act), 32'd0);
      if (k == 655) check("hsync_pre", 32'(hs), 32'd1);
      if (k == 656) check("hsync_fall", 32'(hs), 32'd0);
      if (k == 656) check("hsync_pos_rise", 32'(p1_hs), 32'd1);
      if (k == 751) check("hsync_last", 32'(hs), 32'd0);
      if (k == 752) check("hsync_rise", 32'(hs), 32'd1);
      if (k == 799) check("line_end_x", 32'(px), 32'd799);
      if (k == 799) check("line_end_y", 32'(py), 32'd0);
      if (k == 800) begin
        check("wrap_x", 32'(px), 32'd0);
        check("wrap_y", 32'(py), 32'd1);
        check("wrap_line_start", 32'(ls), 32'd1);
        check("wrap_frame_start", 32'(fs), 32'd0);
      end
    end
    check("line_slot_errors", 32'(berr), 32'd0);
    check("small_slot_errors", 32'(serr), 32'd0);
    check("small_fs_count", 32'(s_fs_cnt), 32'd1);
    check("small_frame_len", 32'(s_fs_at), 32'd120);
    check("small_vsync_slots", 32'(s_vs_cnt), 32'd30);
    check("small_active_slots", 32'(s_act_cnt), 32'd32);
    check("small_hsync_slots", 32'(s_hs_cnt), 32'd24);

    // ce alternating: advance every other clock, freeze otherwise.
    froz = 0; adv = 0;
    for (int i = 0; i < 1600; i++) begin
      ce = (i % 2 == 0);
      prev_x = px; prev_y = py; prev_act = act; prev_hs = hs; prev_ls = ls;
      tick();
      if (ce) begin
        if (bx == 799) begin
          bx = 0;
          by = by + 1;
        end else begin
          bx = bx + 1;
        end
        if (px !== 10'(bx) || py !== 10'(by)) adv++;
      end else if (px !== prev_x || py !== prev_y || act !== prev_act || hs !== prev_hs ||
                   ls !== prev_ls) begin
        froz++;
      end
    end
    check("ce_advance_errors", 32'(adv), 32'd0);
    check("ce_frozen_errors", 32'(froz), 32'd0);
    check("ce_line_x", 32'(px), 32'd0);
    check("ce_line_y", 32'(py), 32'd2);
    ce = 1'b0;
    tick();
    check("hold_line_start", 32'(ls), 32'd1);
    check("hold_x", 32'(px), 32'd0);

    // Mid-line reset.
    ce = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    check("pre_reset_x", 32'(px), 32'd300);
    check("pre_reset_y", 32'(py), 32'd2);
    reset = 1'b1;
    tick();
    check("mid_rst_x", 32'(px), 32'd799);
    check("mid_rst_y", 32'(py), 32'd524);
    check("mid_rst_active", 32'(act), 32'd0);
    check("mid_rst_line_start", 32'(ls), 32'd0);
    reset = 1'b0;
    tick();
    check("restart_x", 32'(px), 32'd0);
    check("restart_y", 32'(py), 32'd0);
    check("restart_frame_start", 32'(fs), 32'd1);
    check("restart_active", 32'(act), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
